// File: rtl/input_conditioner_pkg.sv
// Shared defaults and helpers for the button/switch input conditioner.
// Imported by the debounce channel and the top-level conditioner.
package input_conditioner_pkg;

    localparam int DEF_N_INPUTS        = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    // Bits needed to count 0 .. value-1.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned input: polarity fix, 2-FF synchronizer,
// counter debounce and registered rise/fall pulses.
import input_conditioner_pkg::*;

module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d     = raw ^ ACTIVE_LOW;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // New value held long enough: accept it and pulse once.
            stable_d = s2_q;
            cnt_d    = '0;
            rise_d   = s2_q;
            fall_d   = ~s2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// N independent debounced input channels with edge pulses
// and a combined any-change strobe.
import input_conditioner_pkg::*;

module input_conditioner #(
    parameter int N_INPUTS        = DEF_N_INPUTS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] raw_in,
    output logic [N_INPUTS-1:0] level_out,
    output logic [N_INPUTS-1:0] rise_pulse,
    output logic [N_INPUTS-1:0] fall_pulse,
    output logic                any_change
);

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_in[i]),
            .level(level_out[i]),
            .rise (rise_pulse[i]),
            .fall (fall_pulse[i])
        );
    end

    assign any_change = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: window-based reference model,
// per-cycle compare, directed scenarios and random bouncing.
module tb_input_conditioner;

    localparam int N  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] raw_in;
    logic [N-1:0] level_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic         any_change;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    input_conditioner #(
        .N_INPUTS       (N),
        .DEBOUNCE_CYCLES(DC),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Reference model: the logical input reaches the comparison
    // point two edges late; a level is accepted once the last DC
    // compared samples since the previous acceptance all disagree.
    bit           dly [N][2];
    bit           hist[N][$];
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_rise  = '0;
    logic [N-1:0] m_fall  = '0;

    initial begin
        bit l;
        bit s2;
        int ones;
        forever begin
            @(posedge clk);
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N; c++) begin
                if (reset) begin
                    dly[c][0] = 1'b0;
                    dly[c][1] = 1'b0;
                    hist[c].delete();
                    m_level[c] = 1'b0;
                end else begin
                    l  = ~raw_in[c];
                    s2 = dly[c][0];
                    dly[c][0] = dly[c][1];
                    dly[c][1] = l;
                    hist[c].push_back(s2 != m_level[c]);
                    if (hist[c].size() > DC) void'(hist[c].pop_front());
                    ones = 0;
                    foreach (hist[c][j]) if (hist[c][j]) ones++;
                    if (ones == DC) begin
                        m_level[c] = s2;
                        m_rise[c]  = s2;
                        m_fall[c]  = ~s2;
                        hist[c].delete();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("cyc_level", level_out, m_level);
                chk("cyc_rise", rise_pulse, m_rise);
                chk("cyc_fall", fall_pulse, m_fall);
                chk("cyc_any", any_change, |{m_rise, m_fall});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = 4'b1111;
        tick(3);
        chk_on = 1'b1;

        // 1: reset state, idle inputs for 20 cycles
        chk("rst_level", level_out, 4'b0000);
        chk("rst_pulses", {rise_pulse, fall_pulse, any_change}, 9'd0);
        reset = 1'b0;
        tick(20);
        chk("idle_level", level_out, 4'b0000);
        chk("idle_model", m_level, 4'b0000);

        // 2: press ch0, accepted after edge k+5
        raw_in[0] = 1'b0;
        tick(5);
        chk("press_early", level_out[0], 1'b0);
        tick(1);
        chk("press_level", level_out[0], 1'b1);
        chk("press_rise", rise_pulse, 4'b0001);
        chk("press_any", any_change, 1'b1);
        chk("press_model", m_rise, 4'b0001);
        tick(1);
        chk("press_rise_gone", rise_pulse, 4'b0000);
        chk("press_hold", level_out[0], 1'b1);

        // 3: bounce on ch1 rejected, final press accepted
        raw_in[1] = 1'b0;
        tick(3);
        raw_in[1] = 1'b1;
        tick(1);
        raw_in[1] = 1'b0;
        tick(5);
        chk("bounce_early", level_out[1], 1'b0);
        tick(1);
        chk("bounce_rise", rise_pulse, 4'b0010);
        chk("bounce_level", level_out, 4'b0011);

        // 4: release ch0
        raw_in[0] = 1'b1;
        tick(5);
        chk("rel_early", level_out[0], 1'b1);
        tick(1);
        chk("rel_fall", fall_pulse, 4'b0001);
        chk("rel_norise", rise_pulse, 4'b0000);
        chk("rel_level", level_out[0], 1'b0);

        // 5: all channels pressed together
        raw_in = 4'b1111;
        tick(10);
        chk("sim_pre", level_out, 4'b0000);
        raw_in = 4'b0000;
        tick(6);
        chk("sim_rise", rise_pulse, 4'b1111);
        chk("sim_any", any_change, 1'b1);
        tick(1);
        chk("sim_any_gone", any_change, 1'b0);
        chk("sim_level", level_out, 4'b1111);

        // 6: reset in the middle of a debounce
        raw_in = 4'b1111;
        tick(10);
        raw_in = 4'b1011;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("mrst_level", level_out, 4'b0000);
        chk("mrst_pulses", {rise_pulse, fall_pulse}, 8'd0);
        reset = 1'b0;
        tick(5);
        chk("mrst_early", level_out[2], 1'b0);
        tick(1);
        chk("mrst_rise", rise_pulse, 4'b0100);
        chk("mrst_model", m_level, 4'b0100);

        // Random bouncing with occasional resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 9) < 3) raw_in[c] = ~raw_in[c];
            end
            if ((cyc % 500) > 250) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(0, 9) < 8) raw_in[c] = raw_in[c] ^ 1'b0;
                end
                if ($urandom_range(0, 15) != 0) raw_in = raw_in;
            end
            reset = ($urandom_range(0, 299) == 0);
            tick(1 + (((cyc % 500) > 250) ? $urandom_range(0, 8) : 0));
        end
        reset = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
